fpu_long_issuer: RTL and testbench

// - Initiator side of the long-latency FPU interface (en/x/y/z/funct5/rm -> res/valid).
// - Sits between the execute stage and fpu_long_wrapper: accepts one op via valid/ready,

---
 rtl/fpu_long_issuer_pkg.sv | 24 ++
 rtl/fpu_long_watchdog.sv | 40 ++++
 rtl/fpu_long_issuer.sv | 174 +++++++++++++++++
 tb/tb_fpu_long_issuer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_long_issuer_pkg.sv
// Shared definitions for the long-latency FPU issuer: state encoding, the canonical
// quiet NaN returned on a watchdog expiry, and the FPU op-select codes.
package fpu_long_issuer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [31:0] CANON_NAN = 32'h7fc0_0000;

   localparam logic [4:0] F5_FADD   = 5'h00;
   localparam logic [4:0] F5_FSUB   = 5'h01;
   localparam logic [4:0] F5_FMUL   = 5'h02;
   localparam logic [4:0] F5_FDIV   = 5'h03;
   localparam logic [4:0] F5_FSQRT  = 5'h0b;
   localparam logic [4:0] F5_FMADD  = 5'h10;
   localparam logic [4:0] F5_FMSUB  = 5'h11;
   localparam logic [4:0] F5_FNMADD = 5'h12;
   localparam logic [4:0] F5_FNMSUB = 5'h13;

endpackage

// File: rtl/fpu_long_watchdog.sv
// Cycle counter for the in-flight FPU op: cleared on issue, counts while running,
// saturates at TIMEOUT and flags expiry on the last allowed cycle.
module fpu_long_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clear) begin
         cnt_next = '0;
      end else if (run && (cnt_reg != CNT_SAT)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // >= rather than == so a drain entered on the expiry cycle itself still times out
   assign expire = run && (cnt_reg >= CNT_LAST);

endmodule

// File: rtl/fpu_long_issuer.sv
// Hands one op at a time to the long-latency FPU, waits for its result (or the
// watchdog) and offers result+tag to writeback; a flush drains the in-flight op.
module fpu_long_issuer
   import fpu_long_issuer_pkg::*;
#(
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_x,
   input  logic [31:0]      req_y,
   input  logic [31:0]      req_z,
   input  logic [4:0]       req_funct5,
   input  logic [2:0]       req_rm,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             fpu_en,
   output logic [31:0]      fpu_x,
   output logic [31:0]      fpu_y,
   output logic [31:0]      fpu_z,
   output logic [4:0]       fpu_funct5,
   output logic [2:0]       fpu_rm,
   input  logic [31:0]      fpu_res,
   input  logic             fpu_valid,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_res,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy,
   output logic             timeout_err
);

   state_t state_reg, state_next;

   logic             fpu_en_reg, fpu_en_next;
   logic [31:0]      fpu_x_reg, fpu_x_next;
   logic [31:0]      fpu_y_reg, fpu_y_next;
   logic [31:0]      fpu_z_reg, fpu_z_next;
   logic [4:0]       fpu_funct5_reg, fpu_funct5_next;
   logic [2:0]       fpu_rm_reg, fpu_rm_next;
   logic             resp_valid_reg, resp_valid_next;
   logic [31:0]      resp_res_reg, resp_res_next;
   logic [TAG_W-1:0] tag_reg, tag_next;
   logic             timeout_err_reg, timeout_err_next;

   logic wd_clear;
   logic wd_run;
   logic wd_expire;

   fpu_long_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .run    (wd_run),
      .expire (wd_expire)
   );

   always_comb begin
      state_next       = state_reg;
      fpu_en_next      = 1'b0;
      fpu_x_next       = fpu_x_reg;
      fpu_y_next       = fpu_y_reg;
      fpu_z_next       = fpu_z_reg;
      fpu_funct5_next  = fpu_funct5_reg;
      fpu_rm_next      = fpu_rm_reg;
      resp_valid_next  = resp_valid_reg;
      resp_res_next    = resp_res_reg;
      tag_next         = tag_reg;
      timeout_err_next = timeout_err_reg;
      wd_clear         = 1'b0;
      wd_run           = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (req_valid && !flush) begin
               fpu_en_next     = 1'b1;
               fpu_x_next      = req_x;
               fpu_y_next      = req_y;
               fpu_z_next      = req_z;
               fpu_funct5_next = req_funct5;
               fpu_rm_next     = req_rm;
               tag_next        = req_tag;
               wd_clear        = 1'b1;
               state_next      = ST_WAIT;
            end
         end

         ST_WAIT: begin
            wd_run = 1'b1;
            if (flush) begin
               // The FPU op cannot be cancelled; wait for it unless it is finishing now
               state_next = fpu_valid ? ST_IDLE : ST_DRAIN;
            end else if (fpu_valid) begin
               resp_res_next   = fpu_res;
               resp_valid_next = 1'b1;
               state_next      = ST_DONE;
            end else if (wd_expire) begin
               timeout_err_next = 1'b1;
               resp_res_next    = CANON_NAN;
               resp_valid_next  = 1'b1;
               state_next       = ST_DONE;
            end
         end

         ST_DRAIN: begin
            wd_run = 1'b1;
            if (fpu_valid) begin
               state_next = ST_IDLE;
            end else if (wd_expire) begin
               timeout_err_next = 1'b1;
               state_next       = ST_IDLE;
            end
         end

         ST_DONE: begin
            if (resp_ready || flush) begin
               resp_valid_next = 1'b0;
               state_next      = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         fpu_en_reg      <= 1'b0;
         fpu_x_reg       <= '0;
         fpu_y_reg       <= '0;
         fpu_z_reg       <= '0;
         fpu_funct5_reg  <= '0;
         fpu_rm_reg      <= '0;
         resp_valid_reg  <= 1'b0;
         resp_res_reg    <= '0;
         tag_reg         <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         fpu_en_reg      <= fpu_en_next;
         fpu_x_reg       <= fpu_x_next;
         fpu_y_reg       <= fpu_y_next;
         fpu_z_reg       <= fpu_z_next;
         fpu_funct5_reg  <= fpu_funct5_next;
         fpu_rm_reg      <= fpu_rm_next;
         resp_valid_reg  <= resp_valid_next;
         resp_res_reg    <= resp_res_next;
         tag_reg         <= tag_next;
         timeout_err_reg <= timeout_err_next;
      end
   end

   assign req_ready   = (state_reg == ST_IDLE);
   assign busy        = (state_reg != ST_IDLE);
   assign fpu_en      = fpu_en_reg;
   assign fpu_x       = fpu_x_reg;
   assign fpu_y       = fpu_y_reg;
   assign fpu_z       = fpu_z_reg;
   assign fpu_funct5  = fpu_funct5_reg;
   assign fpu_rm      = fpu_rm_reg;
   assign resp_valid  = resp_valid_reg;
   assign resp_res    = resp_res_reg;
   assign resp_tag    = tag_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_fpu_long_issuer.sv
// Scoreboard bench for fpu_long_issuer: a latency-programmable FPU model, a queue of
// expected responses filled at issue time, and an independent response monitor.
module tb_fpu_long_issuer;
   import fpu_long_issuer_pkg::*;

   localparam int TAG_W   = 5;
   localparam int TIMEOUT = 8;
   localparam logic [31:0] NAN_RES = 32'h7fc0_0000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [31:0]      req_x = '0, req_y = '0, req_z = '0;
   logic [4:0]       req_funct5 = '0;
   logic [2:0]       req_rm = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             flush = 1'b0;
   logic             fpu_en;
   logic [31:0]      fpu_x, fpu_y, fpu_z;
   logic [4:0]       fpu_funct5;
   logic [2:0]       fpu_rm;
   logic [31:0]      fpu_res = '0;
   logic             fpu_valid = 1'b0;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [31:0]      resp_res;
   logic [TAG_W-1:0] resp_tag;
   logic             busy;
   logic             timeout_err;

   always #5 clk = ~clk;

   fpu_long_issuer #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_funct5(req_funct5),
      .req_rm(req_rm), .req_tag(req_tag), .flush(flush), .fpu_en(fpu_en),
      .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_z(fpu_z), .fpu_funct5(fpu_funct5),
      .fpu_rm(fpu_rm), .fpu_res(fpu_res), .fpu_valid(fpu_valid),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_res(resp_res),
      .resp_tag(resp_tag), .busy(busy), .timeout_err(timeout_err)
   );

   typedef struct {
      logic [31:0] x, y, z, res;
      logic [4:0]  f;
      logic [2:0]  rm;
      int          lat;
      bit          silent;
   } fpu_op_t;

   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      bit               terr;
      int               cyc;
   } exp_t;

   fpu_op_t fpu_q[$];
   exp_t    exp_q[$];
   int      cyc = 0;
   int      checks = 0;
   int      fails = 0;
   bit      terr_model = 1'b0;
   int      bp_mode = 2;   // 0: random ready, 1: held low, 2: always high

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural FPU: checks the operands it is handed, answers L cycles after fpu_en
   initial begin : fpu_model
      fpu_op_t op;
      int      valid_at;
      logic    prev_en;
      logic [31:0] pend_res;
      valid_at = -1;
      prev_en  = 1'b0;
      pend_res = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            valid_at = -1;
         end else begin
            if (fpu_en) begin
               chk("fpu_en_single_cycle", prev_en, 1'b0);
               if (fpu_q.size() == 0) begin
                  chk("fpu_en_without_accept", fpu_q.size(), 1);
               end else begin
                  op = fpu_q.pop_front();
                  chk("fpu_x", fpu_x, op.x);
                  chk("fpu_y", fpu_y, op.y);
                  chk("fpu_z", fpu_z, op.z);
                  chk("fpu_funct5", fpu_funct5, op.f);
                  chk("fpu_rm", fpu_rm, op.rm);
                  if (!op.silent) begin
                     valid_at = cyc + op.lat;
                     pend_res = op.res;
                  end
               end
            end
            if (fpu_valid) chk("fpu_valid_only_in_flight", busy && !resp_valid, 1'b1);
         end
         prev_en = fpu_en;
         @(posedge clk);
         #1;
         if (valid_at == cyc) begin
            fpu_valid = 1'b1;
            fpu_res   = pend_res;
         end else begin
            fpu_valid = 1'b0;
            fpu_res   = $urandom;
         end
      end
   end

   initial begin : ready_driver
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       resp_ready = ($urandom_range(0, 3) != 0);
            1:       resp_ready = 1'b0;
            default: resp_ready = 1'b1;
         endcase
      end
   end

   initial begin : monitor
      exp_t cur;
      bit   have_cur;
      logic prev_rv;
      have_cur = 1'b0;
      prev_rv  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("req_ready_is_not_busy", req_ready, !busy);
            if (resp_valid && !prev_rv) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_resp_valid", resp_valid, 1'b0);
                  have_cur = 1'b0;
               end else begin
                  cur = exp_q.pop_front();
                  have_cur = 1'b1;
                  $display("resp tag=%0d res=%h terr=%0d cycle=%0d", resp_tag, resp_res, timeout_err, cyc);
                  chk("resp_cycle", cyc, cur.cyc);
                  chk("resp_timeout_err", timeout_err, cur.terr);
               end
            end
            if (resp_valid && have_cur) begin
               chk("resp_res", resp_res, cur.res);
               chk("resp_tag", resp_tag, cur.tag);
               chk("req_ready_low_in_done", req_ready, 1'b0);
            end
         end
         prev_rv = resp_valid;
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle in which fpu_en is high
   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic [4:0] f, input logic [2:0] rm, input logic [TAG_W-1:0] tag,
                        input logic [31:0] res, input int lat, input bit silent,
                        input bit expect_resp, output int e_cyc);
      fpu_op_t op;
      exp_t    ex;
      int      waited;
      waited = 0;
      req_x = x; req_y = y; req_z = z; req_funct5 = f; req_rm = rm; req_tag = tag;
      req_valid = 1'b1;
      @(negedge clk);
      while (!req_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!req_ready) begin
         chk("accept_within_bound", req_ready, 1'b1);
         req_valid = 1'b0;
         e_cyc = -1;
         return;
      end
      e_cyc = cyc + 1;
      op.x = x; op.y = y; op.z = z; op.f = f; op.rm = rm; op.res = res;
      op.lat = lat; op.silent = silent;
      fpu_q.push_back(op);
      if (expect_resp) begin
         ex.res  = silent ? NAN_RES : res;
         ex.tag  = tag;
         ex.terr = silent ? 1'b1 : terr_model;
         ex.cyc  = silent ? e_cyc + TIMEOUT : e_cyc + 1 + lat;
         exp_q.push_back(ex);
      end
      if (silent) terr_model = 1'b1;
      $display("issue tag=%0d x=%h y=%h lat=%0d silent=%0d fpu_en_cycle=%0d", tag, x, y, lat, silent, e_cyc);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_x = $urandom; req_y = $urandom; req_z = $urandom;
      req_funct5 = 5'($urandom); req_rm = 3'($urandom); req_tag = TAG_W'($urandom);
   endtask

   task automatic goto_neg(input int c);
      repeat (c - cyc) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("returns_to_idle", busy, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string n);
      chk({n, "_fpu_en"}, fpu_en, 1'b0);
      chk({n, "_fpu_x"}, fpu_x, 0);
      chk({n, "_fpu_y"}, fpu_y, 0);
      chk({n, "_fpu_z"}, fpu_z, 0);
      chk({n, "_fpu_funct5"}, fpu_funct5, 0);
      chk({n, "_fpu_rm"}, fpu_rm, 0);
      chk({n, "_resp_valid"}, resp_valid, 1'b0);
      chk({n, "_resp_res"}, resp_res, 0);
      chk({n, "_resp_tag"}, resp_tag, 0);
      chk({n, "_timeout_err"}, timeout_err, 1'b0);
      chk({n, "_req_ready"}, req_ready, 1'b1);
      chk({n, "_busy"}, busy, 1'b0);
   endtask

   task automatic pulse_reset(input string n);
      rst = 1'b1;
      terr_model = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_reset(n);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic rand_ops(input int n);
      int e;
      logic [31:0] a, b, c, r;
      for (int i = 0; i < n; i++) begin
         a = $urandom; b = $urandom; c = $urandom; r = $urandom;
         issue(a, b, c, 5'($urandom), 3'($urandom), TAG_W'($urandom), r,
               $urandom_range(1, TIMEOUT - 1), 1'b0, 1'b1, e);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wait_idle();
   endtask

   initial begin : global_bound
      #300000;
      $display("FAIL global_time_limit: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      int e;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic op with L=4
      bp_mode = 2;
      issue(32'h3f80_0000, 32'h4000_0000, 32'h0, F5_FADD, 3'd0, 5'd7, 32'h4040_0000, 4, 1'b0, 1'b1, e);
      wait_idle();

      bp_mode = 0;
      rand_ops(25);

      // Backpressure: response held, new request refused until handshake
      bp_mode = 1;
      issue(32'h4120_0000, 32'h4040_0000, 32'h0, F5_FMUL, 3'd1, 5'd12, 32'h41f0_0000, 3, 1'b0, 1'b1, e);
      goto_neg(e + 4);
      chk("bp_resp_valid_up", resp_valid, 1'b1);
      @(posedge clk);
      #1;
      req_x = 32'h1234_5678; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_no_fpu_en", fpu_en, 1'b0);
         chk("bp_resp_held", resp_valid, 1'b1);
         @(posedge clk);
         #1;
      end
      bp_mode = 2;
      issue(32'h1234_5678, 32'h9abc_def0, 32'h1111_2222, F5_FDIV, 3'd2, 5'd21, 32'h0bad_f00d, 2, 1'b0, 1'b1, e);
      wait_idle();

      // Flush in WAIT -> DRAIN, FPU result swallowed, then tag 3 completes
      issue(32'h4000_0000, 32'h4000_0000, 32'h0, F5_FSQRT, 3'd0, 5'd9, 32'hdead_beef, 6, 1'b0, 1'b0, e);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      goto_neg(e + 6);
      chk("drain_holds_until_valid", busy, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("drain_exits_after_valid", busy, 1'b0);
      @(posedge clk);
      #1;
      issue(32'h3f80_0000, 32'h3f80_0000, 32'h0, F5_FADD, 3'd0, 5'd3, 32'h4000_0000, 2, 1'b0, 1'b1, e);
      wait_idle();

      // Flush in the same cycle as fpu_valid
      issue(32'h5555_0000, 32'h0000_aaaa, 32'h0, F5_FSUB, 3'd3, 5'd17, 32'hcafe_0001, 3, 1'b0, 1'b0, e);
      repeat (3) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_with_valid_idle", req_ready, 1'b1);
      chk("flush_with_valid_no_resp", resp_valid, 1'b0);
      @(posedge clk);
      #1;

      // Flush together with req_valid in IDLE: not accepted
      req_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_blocks_accept_en", fpu_en, 1'b0);
      chk("flush_blocks_accept_busy", busy, 1'b0);
      @(posedge clk);
      #1;

      // Reset in WAIT
      issue(32'h0101_0101, 32'h0202_0202, 32'h0303_0303, F5_FMADD, 3'd4, 5'd30, 32'h1, 6, 1'b0, 1'b0, e);
      @(posedge clk);
      #1;
      pulse_reset("rst_in_wait");

      // Reset in DONE
      bp_mode = 1;
      issue(32'h0a0a_0a0a, 32'h0b0b_0b0b, 32'h0, F5_FNMSUB, 3'd5, 5'd14, 32'h7777_8888, 2, 1'b0, 1'b1, e);
      goto_neg(e + 3);
      chk("done_before_rst", resp_valid, 1'b1);
      @(posedge clk);
      #1;
      pulse_reset("rst_in_done");
      bp_mode = 2;

      // Watchdog during DRAIN: silent FPU after a flush
      issue(32'hffff_0000, 32'h0, 32'h0, F5_FDIV, 3'd0, 5'd2, 32'h0, 1, 1'b1, 1'b0, e);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      goto_neg(e + TIMEOUT - 1);
      chk("drain_timeout_not_yet", timeout_err, 1'b0);
      chk("drain_timeout_busy", busy, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("drain_timeout_err", timeout_err, 1'b1);
      chk("drain_timeout_idle", busy, 1'b0);
      @(posedge clk);
      #1;
      pulse_reset("rst_after_drain_timeout");

      // Watchdog during WAIT: canonical NaN, sticky error
      issue(32'h4049_0fdb, 32'h0, 32'h0, F5_FSQRT, 3'd0, 5'd11, 32'h0, 1, 1'b1, 1'b1, e);
      goto_neg(e + TIMEOUT - 1);
      chk("timeout_not_early_resp", resp_valid, 1'b0);
      chk("timeout_not_early_err", timeout_err, 1'b0);
      @(posedge clk);
      #1;
      wait_idle();

      bp_mode = 0;
      rand_ops(10);
      chk("timeout_err_sticky", timeout_err, 1'b1);

      bp_mode = 2;
      pulse_reset("final_reset");
      chk("fpu_queue_consumed", fpu_q.size(), 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
